// File: rtl/vga_sync_rx_if.sv
// Sync inputs and recovered-timing outputs of the VGA sync receiver.
// master: timing source / consumer side; slave: the receiver itself.
interface vga_sync_rx_if;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       de;
    logic       frame_start;
    logic       locked;
    logic [7:0] err_count;

    modport master (
        output VGA_HS, VGA_VS,
        input  pixel_x, pixel_y, de, frame_start, locked, err_count
    );

    modport slave (
        input  VGA_HS, VGA_VS,
        output pixel_x, pixel_y, de, frame_start, locked, err_count
    );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: rebuilds h/v position from HS/VS, checks 640x480@60 timing, reports lock.
// Define VGA_RX_ERRCNT_EN to build the saturating lock-loss counter; otherwise err_count is 0.
//
// state  | meaning
// SEARCH | waiting for a VS edge to start framing
// TRACK  | counting consecutive good frames toward lock
// LOCKED | timing confirmed, de and coordinates valid
module vga_sync_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          VGA_CLK2,
    input  logic          reset,
    vga_sync_rx_if.slave  bus
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] H_ACT_LO  = 11'(H_ACT_START);
    localparam logic [10:0] H_ACT_HI  = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] V_ACT_LO  = 11'(V_ACT_START);
    localparam logic [10:0] V_ACT_HI  = 11'(V_ACT_START + V_ACTIVE);
    localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);

    state_t     state, state_nxt;
    logic [2:0] good_cnt, good_nxt;
    logic       hs_q, vs_q;
    logic       hs_fall, vs_fall;
    logic [9:0] h_count, v_count;
    logic       bad_line;
    logic       line_ok, frame_ok, h_sat;
    logic       h_act, v_act;
    logic       frame_start_q;

    assign hs_fall = hs_q & ~bus.VGA_HS;
    assign vs_fall = vs_q & ~bus.VGA_VS;

    // 11-bit sums keep h_count+1 = 1024 from wrapping onto a small total
    assign line_ok  = (({1'b0, h_count} + 11'd1) == H_TOTAL_W);
    assign h_sat    = (h_count == 10'd1023);
    assign frame_ok = (({1'b0, v_count} + 11'd1) == V_TOTAL_W) && !bad_line
                      && !(hs_fall && !line_ok);

    always_ff @(posedge VGA_CLK2 or negedge reset) begin
        if (!reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            h_count       <= '0;
            v_count       <= '0;
            bad_line      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hs_q          <= bus.VGA_HS;
            vs_q          <= bus.VGA_VS;
            frame_start_q <= vs_fall;

            if (hs_fall)
                h_count <= '0;
            else if (!h_sat)
                h_count <= h_count + 10'd1;

            if (vs_fall)
                v_count <= '0;
            else if (hs_fall && (v_count != 10'd1023))
                v_count <= v_count + 10'd1;

            if (vs_fall)
                bad_line <= 1'b0;
            else if (hs_fall && !line_ok)
                bad_line <= 1'b1;
        end
    end

    always_ff @(posedge VGA_CLK2 or negedge reset) begin
        if (!reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        case (state)
            SEARCH: begin
                if (!h_sat && vs_fall) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            TRACK: begin
                if (h_sat) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end else if (vs_fall) begin
                    if (!frame_ok) begin
                        good_nxt = '0;
                    end else if (({1'b0, good_cnt} + 4'd1) == LOCK_W) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_cnt + 3'd1;
                    end
                end
            end
            LOCKED: begin
                if ((hs_fall && !line_ok) || (vs_fall && !frame_ok) || h_sat) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
    end

`ifdef VGA_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       err_inc;

    assign err_inc = (state == LOCKED) && (state_nxt == SEARCH);

    always_ff @(posedge VGA_CLK2 or negedge reset) begin
        if (!reset)
            err_cnt_q <= '0;
        else if (err_inc && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = 8'd0;
`endif

    assign h_act = ({1'b0, h_count} >= H_ACT_LO) && ({1'b0, h_count} < H_ACT_HI);
    assign v_act = ({1'b0, v_count} >= V_ACT_LO) && ({1'b0, v_count} < V_ACT_HI);

    assign bus.locked      = (state == LOCKED);
    assign bus.de          = bus.locked && h_act && v_act;
    assign bus.pixel_x     = bus.de ? (h_count - H_ACT_LO[9:0]) : 10'd0;
    assign bus.pixel_y     = bus.de ? (v_count - V_ACT_LO[9:0]) : 10'd0;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a scaled-down raster (40x20) so whole frames run quickly.
// Expected outputs are queued per driven cycle and compared after the sampling edge.
module tb_vga_sync_rx;

    localparam int HT = 40, VT = 20, HA0 = 8, HA = 24, VA0 = 3, VA = 14, LF = 2;
    localparam int HS_W = 4, VS_W = 2, FRAME = HT * VT;
`ifdef VGA_RX_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       de;
        logic [9:0] px;
        logic [9:0] py;
        logic       fs;
        logic       lk;
        logic [7:0] err;
    } exp_t;

    logic VGA_CLK2 = 1'b0;
    logic reset    = 1'b0;

    vga_sync_rx_if bus();

    vga_sync_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HA0), .H_ACTIVE(HA),
        .V_ACT_START(VA0), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .VGA_CLK2 (VGA_CLK2),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 VGA_CLK2 = ~VGA_CLK2;

    exp_t sb_q[$];
    int   n_cmp = 0, n_mis = 0;

    // receiver model state, derived from what was driven
    int h_exp, v_exp, vs_cnt, m_err;
    bit p_hs, p_vs, m_bad, m_lk;
    // transmitter state
    int tx_h, tx_v, short_v;
    // per-frame counters
    bit cnt_en;
    int de_cnt, fs_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        h_exp = 0; v_exp = 0; vs_cnt = 0; m_err = 0;
        p_hs = 1'b1; p_vs = 1'b1; m_bad = 1'b0; m_lk = 1'b0;
    endtask

    task automatic step(input bit hs, input bit vs);
        exp_t e;
        bit   hsf, vsf, line_ok, sat, frame_ok;
        int   old_h, old_v;
        @(negedge VGA_CLK2);
        bus.VGA_HS = hs;
        bus.VGA_VS = vs;
        old_h = h_exp; old_v = v_exp;
        hsf = p_hs && !hs; vsf = p_vs && !vs;
        p_hs = hs; p_vs = vs;
        line_ok  = (old_h + 1 == HT);
        sat      = (old_h == 1023);
        frame_ok = (old_v + 1 == VT) && !m_bad && !(hsf && !line_ok);
        if (vsf) m_bad = 1'b0;
        else if (hsf && !line_ok) m_bad = 1'b1;
        h_exp = hsf ? 0 : (sat ? 1023 : old_h + 1);
        if (vsf) v_exp = 0;
        else if (hsf && old_v < 1023) v_exp = old_v + 1;
        if (m_lk) begin
            if ((hsf && !line_ok) || (vsf && !frame_ok) || sat) begin
                m_lk = 1'b0; vs_cnt = 0;
                if (m_err < 255) m_err++;
            end
        end else if (sat) begin
            vs_cnt = 0;
        end else if (vsf) begin
            if (vs_cnt == 0) vs_cnt = 1;
            else if (!frame_ok) vs_cnt = 1;
            else begin
                vs_cnt++;
                if (vs_cnt == LF + 1) begin
                    m_lk = 1'b1; vs_cnt = 0;
                end
            end
        end
        e.lk  = m_lk;
        e.de  = m_lk && h_exp >= HA0 && h_exp < HA0 + HA && v_exp >= VA0 && v_exp < VA0 + VA;
        e.px  = e.de ? 10'(h_exp - HA0) : 10'd0;
        e.py  = e.de ? 10'(v_exp - VA0) : 10'd0;
        e.fs  = vsf;
        e.err = ERR_EN ? 8'(m_err) : 8'd0;
        sb_q.push_back(e);

        @(posedge VGA_CLK2);
        #1;
        e = sb_q.pop_front();
        check_val("de", bus.de, e.de);
        check_val("pixel_x", bus.pixel_x, e.px);
        check_val("pixel_y", bus.pixel_y, e.py);
        check_val("frame_start", bus.frame_start, e.fs);
        check_val("locked", bus.locked, e.lk);
        check_val("err_count", bus.err_count, e.err);
        if (cnt_en) begin
            de_cnt += int'(bus.de);
            fs_cnt += int'(bus.frame_start);
        end
    endtask

    task automatic tx_advance();
        int len;
        len = (tx_v == short_v) ? HT - 1 : HT;
        tx_h++;
        if (tx_h >= len) begin
            if (tx_v == short_v) short_v = -1;
            tx_h = 0;
            tx_v = (tx_v + 1) % VT;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step(!(tx_h < HS_W), !(tx_v < VS_W));
            tx_advance();
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_px"}, bus.pixel_x, 0);
        check_val({tag, "_py"}, bus.pixel_y, 0);
        check_val({tag, "_de"}, bus.de, 0);
        check_val({tag, "_fs"}, bus.frame_start, 0);
        check_val({tag, "_lk"}, bus.locked, 0);
        check_val({tag, "_err"}, bus.err_count, 0);
    endtask

    initial begin
        bit found;
        bus.VGA_HS = 1'b1;
        bus.VGA_VS = 1'b1;
        tx_h = 0; tx_v = 0; short_v = -1;
        cnt_en = 1'b0; de_cnt = 0; fs_cnt = 0;
        model_reset();

        // reset state
        repeat (3) @(posedge VGA_CLK2);
        #1;
        check_zero("reset");
        reset = 1'b1;

        // nominal lock, then count one fully locked frame
        run_cycles(3 * FRAME);
        cnt_en = 1'b1;
        run_cycles(FRAME);
        cnt_en = 1'b0;
        check_val("de_per_frame", de_cnt, HA * VA);
        check_val("fs_per_frame", fs_cnt, 1);
        check_val("locked_nominal", bus.locked, 1);

        // one short line, then relock
        short_v = 5;
        run_cycles(4 * FRAME);
        check_val("locked_after_bad", bus.locked, 1);
        check_val("err_after_bad", bus.err_count, ERR_EN ? 1 : 0);

        // sync loss: HS/VS held high from just after a line start
        found = 1'b0;
        for (int i = 0; i < 2 * HT && !found; i++) begin
            if (tx_h == 1) found = 1'b1;
            else run_cycles(1);
        end
        check_val("wait_line_start", found, 1);
        for (int i = 0; i < 1100; i++) step(1'b1, 1'b1);
        check_val("locked_after_loss", bus.locked, 0);
        check_val("err_after_loss", bus.err_count, ERR_EN ? 2 : 0);
        tx_h = 0; tx_v = 5;
        run_cycles(4 * FRAME);
        check_val("locked_after_resync", bus.locked, 1);

        // async reset mid-frame with both syncs high
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (tx_h == 20 && tx_v == 10) found = 1'b1;
            else run_cycles(1);
        end
        check_val("wait_mid_frame", found, 1);
        @(negedge VGA_CLK2);
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge VGA_CLK2);
            bus.VGA_HS = !(tx_h < HS_W);
            bus.VGA_VS = !(tx_v < VS_W);
            tx_advance();
            @(posedge VGA_CLK2);
            #1;
            check_zero("in_rst");
        end
        reset = 1'b1;
        model_reset();
        run_cycles(4 * FRAME);
        check_val("locked_after_rst", bus.locked, 1);
        check_val("err_after_rst", bus.err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
